genius_memory_game: RTL and testbench

Single-player "Genius" memory game: a fixed 16-step colour sequence (4 one-hot buttons/LEDs) must be repeated by the player over rounds of growing length. A control FSM and a datapath (ROM, counters, timers, comparator, edge detector) form one block. It sits at board top level, driving LEDs and seven-segment debug displays, with a one-time "joker" button.

---
 rtl/genius_memory_game.sv | 241 ++++++++++++++++++++++++
 tb/tb_genius_memory_game.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/genius_memory_game.sv
// Genius memory game: a fixed 16-step colour sequence that the player repeats over growing rounds.
// One control FSM plus a datapath (ROM, counters, shared timer, comparator, button edge detector).
module genius_memory_game #(
  parameter int T_INIT    = 2000,
  parameter int T_PAUSE   = 500,
  parameter int T_TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic       botao_coringa,
  output logic [3:0] leds,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       led_coringa,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_rodada,
  output logic       db_clock,
  output logic       db_jogada_correta,
  output logic       db_tem_jogada,
  output logic       db_enderecoIgualRodada,
  output logic       db_timeout
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA_INICIAL = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h8,
    PAUSA          = 4'h9,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } state_t;

  // One shared timer serves the initial display, the pause and the play timeout;
  // each phase clears it on entry, so a phase of N clocks ends when it reads N-1.
  localparam logic [12:0] INIT_LAST    = 13'(T_INIT - 1);
  localparam logic [12:0] PAUSE_LAST   = 13'(T_PAUSE - 1);
  localparam logic [12:0] TIMEOUT_LAST = 13'(T_TIMEOUT - 1);

  function automatic logic [3:0] rom_data(input logic [3:0] addr);
    logic [3:0] d;
    case (addr)
      4'd0:  d = 4'b0001;
      4'd1:  d = 4'b0010;
      4'd2:  d = 4'b0100;
      4'd3:  d = 4'b1000;
      4'd4:  d = 4'b0100;
      4'd5:  d = 4'b0010;
      4'd6:  d = 4'b0001;
      4'd7:  d = 4'b0001;
      4'd8:  d = 4'b0010;
      4'd9:  d = 4'b0010;
      4'd10: d = 4'b0100;
      4'd11: d = 4'b0100;
      4'd12: d = 4'b1000;
      4'd13: d = 4'b1000;
      4'd14: d = 4'b0001;
      default: d = 4'b0100;
    endcase
    return d;
  endfunction

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t      state;
  logic [3:0]  endereco;
  logic [3:0]  rodada;
  logic [3:0]  jogada;
  logic [3:0]  botoes_prev;
  logic [12:0] timer;
  logic        coringa_disp;
  logic        ganhou_r;
  logic        perdeu_r;
  logic        pronto_r;
  logic        timeout_r;
  logic [3:0]  rom_atual;
  logic        tem_jogada;

  assign rom_atual  = rom_data(endereco);
  assign tem_jogada = (botoes_prev == 4'b0000) && (botoes != 4'b0000);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) botoes_prev <= 4'b0000;
    else        botoes_prev <= botoes;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= INICIAL;
      endereco     <= 4'd0;
      rodada       <= 4'd0;
      jogada       <= 4'd0;
      timer        <= 13'd0;
      coringa_disp <= 1'b1;
      ganhou_r     <= 1'b0;
      perdeu_r     <= 1'b0;
      pronto_r     <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      case (state)
        INICIAL: begin
          if (jogar) state <= PREPARACAO;
        end
        PREPARACAO: begin
          endereco     <= 4'd0;
          rodada       <= 4'd0;
          jogada       <= 4'd0;
          timer        <= 13'd0;
          coringa_disp <= 1'b1;
          ganhou_r     <= 1'b0;
          perdeu_r     <= 1'b0;
          pronto_r     <= 1'b0;
          timeout_r    <= 1'b0;
          state        <= MOSTRA_INICIAL;
        end
        MOSTRA_INICIAL: begin
          if (timer == INIT_LAST) begin
            timer <= 13'd0;
            state <= ESPERA;
          end else begin
            timer <= timer + 13'd1;
          end
        end
        ESPERA: begin
          // The play is latched here because the button may already be released in REGISTRA.
          if (tem_jogada) begin
            jogada <= botoes;
            state  <= REGISTRA;
          end else if (!botao_coringa && coringa_disp) begin
            jogada       <= rom_atual;
            coringa_disp <= 1'b0;
            state        <= REGISTRA;
          end else if (timer == TIMEOUT_LAST) begin
            perdeu_r  <= 1'b1;
            pronto_r  <= 1'b1;
            timeout_r <= 1'b1;
            state     <= FIM_TIMEOUT;
          end else begin
            timer <= timer + 13'd1;
          end
        end
        REGISTRA: begin
          state <= COMPARA;
        end
        COMPARA: begin
          if (jogada != rom_atual) begin
            perdeu_r <= 1'b1;
            pronto_r <= 1'b1;
            state    <= FIM_ERRO;
          end else if (endereco != rodada) begin
            state <= PROXIMO;
          end else if (rodada == 4'd15) begin
            ganhou_r <= 1'b1;
            pronto_r <= 1'b1;
            state    <= FIM_ACERTO;
          end else begin
            state <= PROXIMA_RODADA;
          end
        end
        PROXIMO: begin
          endereco <= endereco + 4'd1;
          timer    <= 13'd0;
          state    <= ESPERA;
        end
        PROXIMA_RODADA: begin
          rodada   <= rodada + 4'd1;
          endereco <= 4'd0;
          timer    <= 13'd0;
          state    <= PAUSA;
        end
        PAUSA: begin
          if (timer == PAUSE_LAST) begin
            timer <= 13'd0;
            state <= ESPERA;
          end else begin
            timer <= timer + 13'd1;
          end
        end
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
          if (jogar) state <= PREPARACAO;
        end
        default: state <= INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = 4'b0000;
    if (state == MOSTRA_INICIAL) leds = rom_data(4'd0);
    else if (state == ESPERA)    leds = botoes;
  end

  assign ganhou                 = ganhou_r;
  assign perdeu                 = perdeu_r;
  assign pronto                 = pronto_r;
  assign led_coringa            = coringa_disp;
  assign db_timeout             = timeout_r;
  assign db_contagem            = hex7(endereco);
  assign db_memoria             = hex7(rom_atual);
  assign db_estado              = hex7(state);
  assign db_jogadafeita         = hex7(jogada);
  assign db_rodada              = hex7(rodada);
  assign db_clock               = clock;
  assign db_jogada_correta      = (jogada == rom_atual);
  assign db_tem_jogada          = tem_jogada;
  assign db_enderecoIgualRodada = (endereco == rodada);

endmodule

// File: tb/tb_genius_memory_game.sv
// Bench for genius_memory_game: random play timing and faults checked against a round/address
// model of the game rules, with the colour sequence and 7-seg table held locally.
module tb_genius_memory_game;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [3:0] botoes;
  logic       botao_coringa;
  logic [3:0] leds;
  logic       ganhou, perdeu, pronto, led_coringa;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;
  logic       db_clock, db_jogada_correta, db_tem_jogada, db_enderecoIgualRodada, db_timeout;

  genius_memory_game dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .botao_coringa(botao_coringa), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
    .pronto(pronto), .led_coringa(led_coringa), .db_contagem(db_contagem),
    .db_memoria(db_memoria), .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
    .db_rodada(db_rodada), .db_clock(db_clock), .db_jogada_correta(db_jogada_correta),
    .db_tem_jogada(db_tem_jogada), .db_enderecoIgualRodada(db_enderecoIgualRodada),
    .db_timeout(db_timeout)
  );

  always #10 clock = ~clock;

  logic [3:0] rom [16];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
    int n;
    n = 0;
    while (db_estado !== seg(code) && n < budget) begin
      step(1);
      n++;
    end
    if (db_estado !== seg(code)) chk(tag, db_estado, seg(code));
  endtask

  task automatic count_state(input logic [3:0] code, input int budget, output int n);
    n = 0;
    while (db_estado === seg(code) && n < budget) begin
      step(1);
      n++;
    end
  endtask

  // Round r asks for addresses 0..r; bad_addr (if >= 0) gets bad_col and ends the round there.
  task automatic play_round(input int r, input int bad_addr, input logic [3:0] bad_col);
    logic [3:0] col;
    int hold;
    int n;
    for (int a = 0; a <= r; a++) begin
      wait_state(4'h3, 1000, "wait_espera");
      step($urandom_range(0, 4));
      col  = (a == bad_addr) ? bad_col : rom[a];
      hold = (a == r || a == bad_addr) ? 1 : $urandom_range(1, 6);
      botoes = col;
      #1;
      if (a == 0) chk("leds_echo", leds, col);
      step(hold);
      botoes = 4'b0000;
      step(1);
      if (a == bad_addr) return;
    end
    if (r < 15) begin
      wait_state(4'h9, 10, "reach_pausa");
      count_state(4'h9, 1000, n);
      chk("pause_len", n, 500);
      chk("round_next", db_rodada, seg(4'(r + 1)));
    end
  endtask

  task automatic restart();
    jogar = 1'b1;
    wait_state(4'h2, 10, "reach_mostra");
    jogar = 1'b0;
    chk("restart_coringa", led_coringa, 1'b1);
    chk("restart_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0000);
    chk("restart_leds", leds, rom[0]);
    wait_state(4'h3, 2100, "reach_espera");
  endtask

  initial begin
    int n;
    int rw, aw;
    logic [3:0] bad;
    rom = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
            4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

    reset = 1'b0; jogar = 1'b0; botoes = 4'b0000; botao_coringa = 1'b1;
    step(3);
    reset = 1'b1;
    step(10);
    chk("reset_state", db_estado, seg(4'h0));
    chk("reset_leds", leds, 4'b0000);
    chk("reset_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0000);
    chk("reset_coringa", led_coringa, 1'b1);
    chk("reset_round", db_rodada, seg(4'h0));

    // Start and initial display length
    jogar = 1'b1;
    wait_state(4'h2, 10, "reach_mostra");
    jogar = 1'b0;
    chk("mostra_leds", leds, 4'b0001);
    count_state(4'h2, 3000, n);
    chk("mostra_len", n, 2000);
    chk("after_mostra", db_estado, seg(4'h3));

    // Full winning game
    for (int r = 0; r < 16; r++) play_round(r, -1, 4'b0000);
    wait_state(4'hA, 10, "reach_acerto");
    chk("win_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b1010);
    step(20);
    chk("win_held", db_estado, seg(4'hA));

    // Wrong play: one directed case, one random round/address/colour
    for (int g = 0; g < 2; g++) begin
      restart();
      if (g == 0) begin
        rw = 2; aw = 2; bad = 4'b1000;
      end else begin
        rw = $urandom_range(1, 4);
        aw = $urandom_range(0, rw);
        bad = 4'b0001 << $urandom_range(0, 3);
        while (bad == rom[aw]) bad = 4'b0001 << $urandom_range(0, 3);
      end
      for (int r = 0; r < rw; r++) play_round(r, -1, 4'b0000);
      play_round(rw, aw, bad);
      wait_state(4'hE, 10, "reach_erro");
      chk("err_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0110);
      chk("err_play", db_jogadafeita, seg(bad));
    end

    // Timeout
    restart();
    count_state(4'h3, 6000, n);
    chk("timeout_len", n, 5000);
    chk("timeout_state", db_estado, seg(4'hD));
    chk("timeout_flags", {ganhou, perdeu, pronto, db_timeout}, 4'b0111);

    // Joker: first use accepted, second ignored, restored by restart
    restart();
    botao_coringa = 1'b0;
    step(3);
    botao_coringa = 1'b1;
    chk("joker_used", led_coringa, 1'b0);
    chk("joker_play", db_jogadafeita, seg(rom[0]));
    wait_state(4'h3, 700, "joker_espera");
    chk("joker_round", db_rodada, seg(4'h1));
    botao_coringa = 1'b0;
    step(4);
    chk("joker2_state", db_estado, seg(4'h3));
    chk("joker2_addr", db_contagem, seg(4'h0));
    botao_coringa = 1'b1;
    step(1);
    play_round(1, -1, 4'b0000);
    chk("joker_still_used", led_coringa, 1'b0);
    play_round(2, 0, 4'b1000);
    wait_state(4'hE, 10, "joker_erro");
    chk("joker_err", perdeu, 1'b1);
    restart();

    // Asynchronous reset mid-game
    step(7);
    reset = 1'b0;
    #1;
    chk("midreset_state", db_estado, seg(4'h0));
    chk("midreset_leds", {leds, led_coringa}, 5'b00001);
    reset = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
